// File: rtl/uart_baud_ctrl.sv
// Baud divisor controller: holds dvsr for the baud generator and takes new values from software or 0x55 autobaud (build with UART_ABR_EN).
// Latency: write-to-apply 1 edge when idle; new divisors are held pending while tx/rx are busy, and every change pulses baud_clr_o.
module uart_baud_ctrl #(
    parameter logic [10:0] DEFAULT_DVSR = 11'd650,
    parameter logic [10:0] MIN_DVSR     = 11'd3,
    parameter int          CNT_W        = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_i,
    input  logic        cfg_wr_i,
    input  logic [10:0] cfg_dvsr_i,
    input  logic        abr_start_i,
    input  logic        tx_busy_i,
    input  logic        rx_busy_i,
    output logic [10:0] dvsr_o,
    output logic        baud_clr_o,
    output logic        pending_o,
    output logic        abr_busy_o,
    output logic        abr_done_o,
    output logic        abr_err_o
);

    logic [10:0] dvsr_q, dvsr_d;
    logic [10:0] pend_dvsr_q, pend_dvsr_d;
    logic        pending_q, pending_d;
    logic        baud_clr_q, baud_clr_d;
    logic        abr_load;
    logic [10:0] abr_dvsr;

`ifdef UART_ABR_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_START,
        S_MEASURE,
        S_CALC
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         edges_q, edges_d;
    logic               rx_q, rx_qq;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               fall;
    logic [CNT_W-1:0]   q_full;

    // Both ends of the span see the same register delay, so it cancels out.
    assign fall   = rx_qq & ~rx_q;
    assign q_full = (cnt_q + CNT_W'(64)) >> 7;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        edges_d  = edges_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        abr_load = 1'b0;
        abr_dvsr = q_full[10:0] - 11'd1;
        if (cfg_wr_i) begin
            // Software write aborts any measurement silently.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (abr_start_i) state_d = S_ARM;
                end
                S_ARM: begin
                    if (rx_q) state_d = S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (fall) begin
                        cnt_d   = '0;
                        edges_d = 2'd0;
                        state_d = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (fall && edges_q == 2'd3) begin
                        state_d = S_CALC;
                    end else if (cnt_q == {CNT_W{1'b1}}) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (fall) begin
                        edges_d = edges_q + 2'd1;
                    end
                end
                S_CALC: begin
                    if (q_full > CNT_W'(2048) || q_full < CNT_W'(MIN_DVSR) + CNT_W'(1)) begin
                        err_d = 1'b1;
                    end else begin
                        abr_load = 1'b1;
                        done_d   = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            edges_q <= 2'd0;
            rx_q    <= 1'b1;
            rx_qq   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edges_q <= edges_d;
            rx_q    <= rx_i;
            rx_qq   <= rx_q;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign abr_busy_o = busy_q;
    assign abr_done_o = done_q;
    assign abr_err_o  = err_q;
`else
    logic unused_abr;
    assign unused_abr = &{1'b0, rx_i, abr_start_i};
    assign abr_load   = 1'b0;
    assign abr_dvsr   = 11'd0;
    assign abr_busy_o = 1'b0;
    assign abr_done_o = 1'b0;
    assign abr_err_o  = 1'b0;
`endif

    // Apply first, then load: a same-edge write applies the old value and stays pending.
    always_comb begin
        dvsr_d      = dvsr_q;
        pend_dvsr_d = pend_dvsr_q;
        pending_d   = pending_q;
        baud_clr_d  = 1'b0;
        if (pending_q && !tx_busy_i && !rx_busy_i) begin
            dvsr_d     = pend_dvsr_q;
            pending_d  = 1'b0;
            baud_clr_d = 1'b1;
        end
        if (cfg_wr_i) begin
            pend_dvsr_d = cfg_dvsr_i;
            pending_d   = 1'b1;
        end else if (abr_load) begin
            pend_dvsr_d = abr_dvsr;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvsr_q      <= DEFAULT_DVSR;
            pend_dvsr_q <= 11'd0;
            pending_q   <= 1'b0;
            baud_clr_q  <= 1'b0;
        end else begin
            dvsr_q      <= dvsr_d;
            pend_dvsr_q <= pend_dvsr_d;
            pending_q   <= pending_d;
            baud_clr_q  <= baud_clr_d;
        end
    end

    assign dvsr_o     = dvsr_q;
    assign pending_o  = pending_q;
    assign baud_clr_o = baud_clr_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Self-checking bench for uart_baud_ctrl: vector table for write/pending/apply, hand sequences for busy hold and autobaud.
module tb_uart_baud_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_i;
    logic        cfg_wr_i;
    logic [10:0] cfg_dvsr_i;
    logic        abr_start_i;
    logic        tx_busy_i;
    logic        rx_busy_i;
    logic [10:0] dvsr_o;
    logic        baud_clr_o;
    logic        pending_o;
    logic        abr_busy_o;
    logic        abr_done_o;
    logic        abr_err_o;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_clr  = 0;

    uart_baud_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .cfg_wr_i   (cfg_wr_i),
        .cfg_dvsr_i (cfg_dvsr_i),
        .abr_start_i(abr_start_i),
        .tx_busy_i  (tx_busy_i),
        .rx_busy_i  (rx_busy_i),
        .dvsr_o     (dvsr_o),
        .baud_clr_o (baud_clr_o),
        .pending_o  (pending_o),
        .abr_busy_o (abr_busy_o),
        .abr_done_o (abr_done_o),
        .abr_err_o  (abr_err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (abr_done_o) n_done++;
            if (abr_err_o)  n_err++;
            if (baud_clr_o) n_clr++;
        end
    end

    typedef struct {
        logic        wr;
        logic [10:0] wdat;
        logic        txb;
        logic        rxb;
        logic [10:0] exp_dvsr;
        logic        exp_pend;
        logic        exp_clr;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dvsr"}, int'(dvsr_o), 650);
        chk({tag, "_clr"}, int'(baud_clr_o), 0);
        chk({tag, "_pend"}, int'(pending_o), 0);
        chk({tag, "_abr"}, int'({abr_busy_o, abr_done_o, abr_err_o}), 0);
    endtask

    task automatic pulse_start();
        abr_start_i = 1'b1;
        tick(1);
        abr_start_i = 1'b0;
    endtask

    // Drives start bit, nbits data bits LSB first, then stop bit if the frame completes.
    task automatic send_frame(input logic [7:0] b, input int bt, input int nbits);
        rx_i = 1'b0;
        tick(bt);
        for (int i = 0; i < nbits; i++) begin
            rx_i = b[i];
            tick(bt);
        end
        if (nbits == 8) begin
            rx_i = 1'b1;
            tick(bt);
        end
    endtask

    task automatic write_dvsr(input logic [10:0] v);
        cfg_wr_i   = 1'b1;
        cfg_dvsr_i = v;
        tick(1);
        cfg_wr_i   = 1'b0;
    endtask

    initial begin
        int d0, e0, c0;
        rst_n = 1'b0; rx_i = 1'b1; cfg_wr_i = 1'b0; cfg_dvsr_i = 11'd0;
        abr_start_i = 1'b0; tx_busy_i = 1'b0; rx_busy_i = 1'b0;

        //          wr    wdat      txb   rxb   dvsr      pend  clr
        vecs[0]  = '{1'b0, 11'd0,    1'b0, 1'b0, 11'd650,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 11'd53,   1'b0, 1'b0, 11'd650,  1'b1, 1'b0};
        vecs[2]  = '{1'b0, 11'd0,    1'b0, 1'b0, 11'd53,   1'b0, 1'b1};
        vecs[3]  = '{1'b0, 11'd0,    1'b0, 1'b0, 11'd53,   1'b0, 1'b0};
        vecs[4]  = '{1'b1, 11'd100,  1'b1, 1'b0, 11'd53,   1'b1, 1'b0};
        vecs[5]  = '{1'b0, 11'd0,    1'b1, 1'b0, 11'd53,   1'b1, 1'b0};
        vecs[6]  = '{1'b0, 11'd0,    1'b0, 1'b1, 11'd53,   1'b1, 1'b0};
        vecs[7]  = '{1'b0, 11'd0,    1'b0, 1'b0, 11'd100,  1'b0, 1'b1};
        vecs[8]  = '{1'b1, 11'd7,    1'b0, 1'b0, 11'd100,  1'b1, 1'b0};
        vecs[9]  = '{1'b1, 11'd9,    1'b0, 1'b0, 11'd7,    1'b1, 1'b1};
        vecs[10] = '{1'b0, 11'd0,    1'b0, 1'b0, 11'd9,    1'b0, 1'b1};
        vecs[11] = '{1'b0, 11'd0,    1'b0, 1'b0, 11'd9,    1'b0, 1'b0};
        vecs[12] = '{1'b1, 11'd2047, 1'b1, 1'b1, 11'd9,    1'b1, 1'b0};
        vecs[13] = '{1'b1, 11'd0,    1'b1, 1'b0, 11'd9,    1'b1, 1'b0};
        vecs[14] = '{1'b0, 11'd0,    1'b0, 1'b0, 11'd0,    1'b0, 1'b1};
        vecs[15] = '{1'b1, 11'd650,  1'b0, 1'b0, 11'd0,    1'b1, 1'b0};
        vecs[16] = '{1'b0, 11'd0,    1'b0, 1'b0, 11'd650,  1'b0, 1'b1};

        tick(2);
        check_reset_vals("in_reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cfg_wr_i   = vecs[i].wr;
            cfg_dvsr_i = vecs[i].wdat;
            tx_busy_i  = vecs[i].txb;
            rx_busy_i  = vecs[i].rxb;
            tick(1);
            chk($sformatf("vec%0d_dvsr", i), int'(dvsr_o), int'(vecs[i].exp_dvsr));
            chk($sformatf("vec%0d_pend", i), int'(pending_o), int'(vecs[i].exp_pend));
            chk($sformatf("vec%0d_clr", i), int'(baud_clr_o), int'(vecs[i].exp_clr));
            chk($sformatf("vec%0d_abr", i), int'({abr_busy_o, abr_done_o, abr_err_o}), 0);
        end
        cfg_wr_i = 1'b0; tx_busy_i = 1'b0; rx_busy_i = 1'b0;

        // Long transmitter busy holds the divisor pending.
        tx_busy_i = 1'b1;
        write_dvsr(11'd100);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (pending_o !== 1'b1 || dvsr_o !== 11'd650 || baud_clr_o !== 1'b0)
                chk($sformatf("busy_hold_c%0d", i), int'({pending_o, baud_clr_o, dvsr_o}), int'({1'b1, 1'b0, 11'd650}));
        end
        chk("busy_hold_pend", int'(pending_o), 1);
        tx_busy_i = 1'b0;
        tick(1);
        chk("busy_release_dvsr", int'(dvsr_o), 100);
        chk("busy_release_clr", int'(baud_clr_o), 1);
        chk("busy_release_pend", int'(pending_o), 0);
        tick(1);
        chk("busy_release_clr_off", int'(baud_clr_o), 0);

`ifdef UART_ABR_EN
        // Autobaud success: 864 clk/bit -> cnt 6912, q 54, divisor 53.
        d0 = n_done; e0 = n_err; c0 = n_clr;
        pulse_start();
        chk("abr864_busy", int'(abr_busy_o), 1);
        tick(3);
        send_frame(8'h55, 864, 8);
        tick(4);
        chk("abr864_done", n_done - d0, 1);
        chk("abr864_err", n_err - e0, 0);
        chk("abr864_clr", n_clr - c0, 1);
        chk("abr864_dvsr", int'(dvsr_o), 53);
        chk("abr864_busy_end", int'(abr_busy_o), 0);

        // Autobaud too fast: 32 clk/bit -> q 2, rejected.
        d0 = n_done; e0 = n_err; c0 = n_clr;
        pulse_start();
        tick(3);
        send_frame(8'h55, 32, 8);
        tick(4);
        chk("abr32_err", n_err - e0, 1);
        chk("abr32_done", n_done - d0, 0);
        chk("abr32_dvsr", int'(dvsr_o), 53);
        chk("abr32_pend", int'(pending_o), 0);
        chk("abr32_clr", n_clr - c0, 0);

        // Reset in the middle of MEASURE.
        d0 = n_done; e0 = n_err;
        pulse_start();
        tick(3);
        send_frame(8'h55, 100, 2);
        chk("rst_mid_busy_pre", int'(abr_busy_o), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        rx_i = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1000);
        chk("rst_mid_nopulse", (n_done - d0) + (n_err - e0), 0);
        check_reset_vals("rst_after");

        // Software write aborts MEASURE.
        d0 = n_done; e0 = n_err;
        pulse_start();
        tick(3);
        send_frame(8'h55, 100, 3);
        chk("wr_abort_busy_pre", int'(abr_busy_o), 1);
        write_dvsr(11'd200);
        chk("wr_abort_busy", int'(abr_busy_o), 0);
        for (int i = 3; i < 8; i++) begin
            rx_i = i[0] ? 1'b0 : 1'b1;
            tick(100);
        end
        rx_i = 1'b1;
        tick(100);
        chk("wr_abort_nopulse", (n_done - d0) + (n_err - e0), 0);
        chk("wr_abort_dvsr", int'(dvsr_o), 200);
        chk("wr_abort_busy_end", int'(abr_busy_o), 0);
`else
        // Without autobaud the start strobe and RX line have no effect.
        d0 = n_done; e0 = n_err; c0 = n_clr;
        pulse_start();
        chk("noabr_busy", int'(abr_busy_o), 0);
        send_frame(8'h55, 32, 8);
        tick(4);
        chk("noabr_pulses", (n_done - d0) + (n_err - e0) + (n_clr - c0), 0);
        chk("noabr_dvsr", int'(dvsr_o), 100);
        chk("noabr_pend", int'(pending_o), 0);
        write_dvsr(11'd200);
        tick(1);
        chk("noabr_wr_dvsr", int'(dvsr_o), 200);
        rst_n = 1'b0;
        #1;
        check_reset_vals("noabr_rst");
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
